// File: rtl/alu_drv_pkg.sv
// Shared definitions for the ALU command driver: select codes, FSM states,
// command byte layout and the reference ALU function.
package alu_drv_pkg;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_AND = 2'b10;
  localparam logic [1:0] SEL_MUL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    HOLD  = 2'b10
  } drv_state_e;

  // Command byte layout: [2:0]=A, [5:3]=B, [7:6]=sel
  localparam int CMD_A_LSB   = 0;
  localparam int CMD_B_LSB   = 3;
  localparam int CMD_SEL_LSB = 6;
  localparam int CMD_OP_W    = 3;
  localparam int CMD_SEL_W   = 2;

  localparam int REF_W = 16;

  // Wide result; callers truncate to their result width to get mod 2^RESW.
  function automatic logic [REF_W-1:0] alu_ref(input logic [1:0] sel,
                                               input logic [7:0] a,
                                               input logic [7:0] b);
    logic [REF_W-1:0] r;
    case (sel)
      SEL_ADD: r = {8'd0, a} + {8'd0, b};
      SEL_SUB: r = {8'd0, a} - {8'd0, b};
      SEL_AND: r = {8'd0, a & b};
      SEL_MUL: r = {8'd0, a} * {8'd0, b};
      default: r = 16'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Command stream, ALU operand/result lines and result stream of the driver.
// master = the driver itself, slave = command source / ALU / result sink.
interface alu_cmd_driver_if #(
  parameter int OPW  = 3,
  parameter int RESW = 6
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [7:0]      cmd_data;
  logic [OPW-1:0]  alu_a;
  logic [OPW-1:0]  alu_b;
  logic [1:0]      alu_sel;
  logic [RESW-1:0] alu_result;
  logic            res_valid;
  logic            res_ready;
  logic [RESW-1:0] res_data;
  logic [1:0]      res_sel;

  modport master (
    input  cmd_valid, cmd_data, alu_result, res_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel
  );

  modport slave (
    output cmd_valid, cmd_data, alu_result, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// DEPTH x WIDTH synchronous FIFO with show-ahead read data and occupancy count.
// Memory is not reset; reset empties the FIFO through the pointers.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    count_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == LW'(DEPTH));
  assign empty  = (count_r == {LW{1'b0}});
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;
  assign rdata  = mem_r[rd_ptr_r];
  assign level  = count_r;

  // Storage write
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + LW'(1);
        2'b01:   count_r <= count_r - LW'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/alu_cmd_driver.sv
// Sequences buffered ALU commands onto the combinational ALU and returns results
// on a valid/ready port. Optional reference checker: ALU_DRIVER_SELFCHECK_EN.
module alu_cmd_driver
  import alu_drv_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1,
  parameter int OPW    = 3,
  parameter int RESW   = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_cmd_driver_if.master       bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
`ifdef ALU_DRIVER_SELFCHECK_EN
  ,
  output logic                   mismatch,
  output logic [7:0]             mismatch_cmd
`endif
);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  drv_state_e      state_r;
  drv_state_e      next_state_s;
  logic [CW-1:0]   cnt_r;
  logic            cnt_zero_s;
  logic [OPW-1:0]  alu_a_r;
  logic [OPW-1:0]  alu_b_r;
  logic [1:0]      alu_sel_r;
  logic            res_valid_r;
  logic [RESW-1:0] res_data_r;
  logic [1:0]      res_sel_r;
  logic            full_s;
  logic            empty_s;
  logic [7:0]      head_s;
  logic            push_s;
  logic            pop_s;
  logic            cnt_dec_s;
  logic            capture_s;
  logic            release_s;
  logic            res_hs_s;

  assign push_s     = bus.cmd_valid & ~full_s;
  assign cnt_zero_s = (cnt_r == {CW{1'b0}});
  assign res_hs_s   = res_valid_r & bus.res_ready;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (bus.cmd_data),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          next_state_s = ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        if (cnt_zero_s) begin
          next_state_s = HOLD;
        end else begin
          next_state_s = ISSUE;
        end
      end
      HOLD: begin
        // Back-to-back issue straight from HOLD avoids an IDLE bubble
        if (res_hs_s) begin
          if (!empty_s) begin
            next_state_s = ISSUE;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          next_state_s = HOLD;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM control strobes
  always_comb begin
    pop_s     = 1'b0;
    cnt_dec_s = 1'b0;
    capture_s = 1'b0;
    release_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      ISSUE: begin
        if (cnt_zero_s) begin
          capture_s = 1'b1;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      HOLD: begin
        if (res_hs_s) begin
          release_s = 1'b1;
          pop_s     = ~empty_s;
        end else begin
          release_s = 1'b0;
        end
      end
      default: begin
        pop_s = 1'b0;
      end
    endcase
  end

  // Operand registers load only on pop, so they stay frozen through ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_r   <= {OPW{1'b0}};
      alu_b_r   <= {OPW{1'b0}};
      alu_sel_r <= 2'b00;
      cnt_r     <= {CW{1'b0}};
    end else begin
      if (pop_s) begin
        alu_a_r   <= OPW'(head_s[CMD_A_LSB +: CMD_OP_W]);
        alu_b_r   <= OPW'(head_s[CMD_B_LSB +: CMD_OP_W]);
        alu_sel_r <= head_s[CMD_SEL_LSB +: CMD_SEL_W];
        cnt_r     <= CW'(SETTLE - 1);
      end else if (cnt_dec_s) begin
        cnt_r <= cnt_r - CW'(1);
      end
    end
  end

  // Result register and valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_r <= 1'b0;
      res_data_r  <= {RESW{1'b0}};
      res_sel_r   <= 2'b00;
    end else begin
      if (capture_s) begin
        res_valid_r <= 1'b1;
        res_data_r  <= bus.alu_result;
        res_sel_r   <= alu_sel_r;
      end else if (release_s) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready = ~full_s;
  assign bus.alu_a     = alu_a_r;
  assign bus.alu_b     = alu_b_r;
  assign bus.alu_sel   = alu_sel_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_data  = res_data_r;
  assign bus.res_sel   = res_sel_r;
  assign busy          = (state_r != IDLE) | ~empty_s;

`ifdef ALU_DRIVER_SELFCHECK_EN
  logic [RESW-1:0] ref_s;
  logic            mismatch_r;
  logic [7:0]      mismatch_cmd_r;

  assign ref_s = RESW'(alu_ref(alu_sel_r, 8'(alu_a_r), 8'(alu_b_r)));

  // Sticky flag; only the first failing command is kept for diagnosis
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_r     <= 1'b0;
      mismatch_cmd_r <= 8'h00;
    end else begin
      if (capture_s && (ref_s != bus.alu_result) && !mismatch_r) begin
        mismatch_r     <= 1'b1;
        mismatch_cmd_r <= {alu_sel_r, 3'(alu_b_r), 3'(alu_a_r)};
      end
    end
  end

  assign mismatch     = mismatch_r;
  assign mismatch_cmd = mismatch_cmd_r;
`endif
endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver (DEPTH=4, SETTLE=1) with a behavioural ALU stub.
// With ALU_DRIVER_SELFCHECK_EN defined, the stub can be made faulty for sel=11.
module tb_alu_cmd_driver;
  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [2:0] level;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] cq [16];
  logic [5:0] eq [16];
  bit         stub_bad = 1'b0;
`ifdef ALU_DRIVER_SELFCHECK_EN
  logic       mismatch;
  logic [7:0] mismatch_cmd;
`endif

  always #5 clk = ~clk;

  alu_cmd_driver_if #(.OPW(3), .RESW(6)) bus ();

  function automatic logic [5:0] stub_alu(input logic [1:0] s, input logic [2:0] a, input logic [2:0] b);
    case (s)
      2'd0:    return 6'(a) + 6'(b);
      2'd1:    return 6'(a) - 6'(b);
      2'd2:    return 6'(a & b);
      default: return 6'(a) * 6'(b);
    endcase
  endfunction

  assign bus.alu_result = stub_alu(bus.alu_sel, bus.alu_a, bus.alu_b)
                          ^ {5'd0, stub_bad && (bus.alu_sel == 2'd3)};

  alu_cmd_driver #(.DEPTH(4), .SETTLE(1), .OPW(3), .RESW(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .level (level)
`ifdef ALU_DRIVER_SELFCHECK_EN
    ,
    .mismatch     (mismatch),
    .mismatch_cmd (mismatch_cmd)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set(input int i, input logic [7:0] c, input logic [5:0] e);
    cq[i] = c;
    eq[i] = e;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data = 8'h00;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Entered and left on a negedge; pushes cq[p0..n-1], expects eq[0..n-1] in order
  task automatic run(input int n, input bit gapchk, input int p0);
    int pi = p0;
    int got = 0;
    int cyc = 0;
    int last = -1;
    bit pp = 1'b0;
    bit hs;
    logic [2:0] lv = 3'd0;
    while (got < n && cyc < 200) begin
      chk("lvl_bound", (level <= 3'd4) ? 32'd1 : 32'd0, 32'd1);
      if (pp) chk("pushpop_lvl", level, lv);
      pp = 1'b0;
      hs = bus.res_valid && bus.res_ready;
      if (hs) begin
        chk("res_data", bus.res_data, eq[got]);
        chk("res_sel", bus.res_sel, cq[got][7:6]);
        if (gapchk && last >= 0) chk("gap", cyc - last, 2);
        last = cyc;
        got++;
      end
      if (pi < n && bus.cmd_ready) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_data = cq[pi];
        pi++;
        pp = hs && (level == 3'd3);
        lv = level;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.cmd_valid = 1'b0;
    chk("all_results", got, n);
  endtask

  initial begin
    int pi;
    do_reset();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_sel", bus.res_sel, 0);
    chk("rst_alu_ops", {bus.alu_sel, bus.alu_b, bus.alu_a}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);

    // Single op: 0x1D = A5 B3 add
    bus.res_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data = 8'h1D;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("s_level1", level, 1);
    chk("s_busy1", busy, 1);
    chk("s_rv_early", bus.res_valid, 0);
    @(negedge clk);
    chk("s_alu_ops", {bus.alu_sel, bus.alu_b, bus.alu_a}, 8'h1D);
    chk("s_rv_early2", bus.res_valid, 0);
    chk("s_level0", level, 0);
    @(negedge clk);
    chk("s_rv", bus.res_valid, 1);
    chk("s_data", bus.res_data, 8);
    chk("s_sel", bus.res_sel, 0);
    @(negedge clk);
    chk("s_rv_clr", bus.res_valid, 0);
    chk("s_busy0", busy, 0);
    chk("s_level_end", level, 0);

    // Streaming sub/and/mul with A=2 B=3
    do_reset();
    bus.res_ready = 1'b1;
    set(0, 8'h5A, 6'h3F);
    set(1, 8'h9A, 6'h02);
    set(2, 8'hDA, 6'h06);
    run(3, 1'b1, 0);
    repeat (2) @(negedge clk);

    // Fill under backpressure, then drain
    do_reset();
    set(0, 8'h09, 6'd2);
    set(1, 8'h12, 6'd4);
    set(2, 8'h1B, 6'd6);
    set(3, 8'h24, 6'd8);
    set(4, 8'h2D, 6'd10);
    set(5, 8'h36, 6'd12);
    pi = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.res_valid) chk("hold_stable", bus.res_data, 2);
      if (pi < 6 && bus.cmd_ready) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_data = cq[pi];
        pi++;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("fill_level", level, 4);
    chk("fill_cmd_ready", bus.cmd_ready, 0);
    chk("fill_accepted", pi, 5);
    chk("fill_rv", bus.res_valid, 1);
    chk("fill_data", bus.res_data, 2);
    bus.res_ready = 1'b1;
    run(6, 1'b0, 5);
    repeat (2) @(negedge clk);

    // 3*DEPTH mixed commands: pointer wrap and push+pop at level 3
    do_reset();
    bus.res_ready = 1'b1;
    set(0, 8'hFF, 6'd49);
    set(1, 8'h48, 6'd63);
    set(2, 8'h37, 6'd13);
    set(3, 8'h9E, 6'd2);
    set(4, 8'hF5, 6'd30);
    set(5, 8'h6B, 6'd62);
    set(6, 8'h11, 6'd3);
    set(7, 8'hAF, 6'd5);
    set(8, 8'hDC, 6'd12);
    set(9, 8'h56, 6'd4);
    set(10, 8'h00, 6'd0);
    set(11, 8'hFB, 6'd21);
    run(12, 1'b1, 0);
    repeat (2) @(negedge clk);

    // Reset while in ISSUE with two commands queued, push during reset
    do_reset();
    set(0, 8'h1D, 6'd8);
    set(1, 8'h37, 6'd13);
    set(2, 8'h11, 6'd3);
    set(3, 8'h9E, 6'd2);
    pi = 0;
    for (int i = 0; i < 6; i++) begin
      if (pi < 4 && bus.cmd_ready) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_data = cq[pi];
        pi++;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("mr_level3", level, 3);
    chk("mr_data", bus.res_data, 8);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("mr_level2", level, 2);
    chk("mr_issue_a", bus.alu_a, 7);
    chk("mr_rv_pre", bus.res_valid, 0);
    rst = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data = 8'hFF;
    @(negedge clk);
    chk("mr_rv", bus.res_valid, 0);
    chk("mr_level0", level, 0);
    chk("mr_alu_ops", {bus.alu_sel, bus.alu_b, bus.alu_a}, 0);
    chk("mr_busy", busy, 0);
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mr_no_stale", bus.res_valid, 0);
    end

`ifdef ALU_DRIVER_SELFCHECK_EN
    // Faulty stub for sel=11 must set the sticky flag and record the command
    do_reset();
    stub_bad = 1'b1;
    bus.res_ready = 1'b1;
    set(0, 8'h1D, 6'd8);
    run(1, 1'b1, 0);
    repeat (2) @(negedge clk);
    chk("sc_clean", mismatch, 0);
    set(0, 8'hFF, 6'h30);
    set(1, 8'h37, 6'd13);
    run(2, 1'b1, 0);
    repeat (2) @(negedge clk);
    chk("sc_mismatch", mismatch, 1);
    chk("sc_cmd", mismatch_cmd, 8'hFF);
    stub_bad = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
